// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked add/subtract pipeline with carry, overflow, zero and sign flags.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cy_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryflag,
    output logic             overflowflag,
    output logic             zeroflag,
    output logic             signflag
);
    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0]            v_q, c_q, z_q, n_v, n_c, n_z;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q, n_a, n_b, n_s;
    logic                         ov_q, n_cm, adv;
    logic [WIDTH-1:0]             ai, bi;
    logic                         ci, zi;
    logic [CW:0]                  r;

    assign adv          = !out_valid || out_ready;
    assign in_ready     = adv;
    assign out_valid    = v_q[STAGES-1];
    assign sum          = s_q[STAGES-1];
    assign carryflag    = c_q[STAGES-1];
    assign overflowflag = ov_q;
    assign zeroflag     = z_q[STAGES-1];
    assign signflag     = sum[WIDTH-1];

    // Stage i takes its inputs from the ports (i == 0) or from stage i-1 and resolves chunk i.
    always_comb begin
        ai   = '0;
        bi   = '0;
        ci   = 1'b0;
        zi   = 1'b0;
        r    = '0;
        n_cm = 1'b0;
        n_a  = '0;
        n_b  = '0;
        n_s  = '0;
        n_c  = '0;
        n_z  = '0;
        n_v  = '0;
        for (int i = 0; i < STAGES; i++) begin
            ai     = i == 0 ? a : a_q[i == 0 ? 0 : i - 1];
            bi     = i == 0 ? (op[0] ? ~b : b) : b_q[i == 0 ? 0 : i - 1];
            ci     = i == 0 ? (op[1] ? cy_in : op[0]) : c_q[i == 0 ? 0 : i - 1];
            zi     = i == 0 ? 1'b1 : z_q[i == 0 ? 0 : i - 1];
            n_v[i] = i == 0 ? in_valid : v_q[i == 0 ? 0 : i - 1];
            n_s[i] = i == 0 ? '0 : s_q[i == 0 ? 0 : i - 1];
            r      = {1'b0, ai[i*CW +: CW]} + {1'b0, bi[i*CW +: CW]} + {{CW{1'b0}}, ci};
            n_s[i][i*CW +: CW] = r[CW-1:0];
            n_a[i] = ai;
            n_b[i] = bi;
            n_c[i] = r[CW];
            n_z[i] = zi && (r[CW-1:0] == '0);
            if (i == STAGES - 1)
                n_cm = ai[WIDTH-1] ^ bi[WIDTH-1] ^ r[CW-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            c_q  <= '0;
            z_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            s_q  <= '0;
            ov_q <= 1'b0;
        end else if (adv) begin
            v_q  <= n_v;
            c_q  <= n_c;
            z_q  <= n_z;
            a_q  <= n_a;
            b_q  <= n_b;
            s_q  <= n_s;
            ov_q <= n_cm ^ n_c[STAGES-1];
        end
    end
endmodule
